data_mem: RTL and testbench

Parametrised, byte-addressable data memory with a valid/ready request/response interface for the CPU load/store path. It supersedes the fixed-size, write-strobe-only data RAM:
- stores are aligned into byte lanes;
- reads are registered;
- loads are sign- or zero-extended inside the block;
- misaligned, out-of-range and illegal-size accesses are flagged instead of corrupting memory.

It sits between the execute stage and the storage array, and can stall the core through `req_ready`.

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/data_mem_align.sv | 60 ++++++
 rtl/data_mem.sv | 78 +++++++
 tb/tb_data_mem.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the byte-addressable data memory.
// Size codes match the load/store unit's encoding on this path.
package data_mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = NUM_LANES * LANE_W;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/data_mem_align.sv
// Combinational size/offset decode: lane enables, store replication,
// load extract/extend and access-error detection.
module data_mem_align
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic [1:0]                         size,
  input  logic                               uns,
  input  logic [31:0]                        addr,
  input  logic [WORD_W-1:0]                  wdata,
  input  logic [WORD_W-1:0]                  rword,
  output logic [NUM_LANES-1:0]               lane_en,
  output logic [NUM_LANES-1:0][LANE_W-1:0]   wlanes,
  output logic [WORD_W-1:0]                  ldata,
  output logic                               err
);

  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [1:0]  off;
  logic        oor;
  logic        misalign;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign off   = addr[1:0];
  assign oor   = {1'b0, addr} >= LIMIT;
  assign sel_b = rword[{off, 3'b000} +: 8];
  // Half select ignores off[0]; odd offsets are flagged as errors anyway.
  assign sel_h = rword[{off[1], 4'b0000} +: 16];

  always_comb begin
    lane_en  = '0;
    wlanes   = wdata;
    ldata    = rword;
    misalign = 1'b0;
    case (size)
      MEM_SIZE_B: begin
        lane_en = 4'b0001 << off;
        wlanes  = {4{wdata[7:0]}};
        ldata   = {{24{~uns & sel_b[7]}}, sel_b};
      end
      MEM_SIZE_H: begin
        misalign = off[0];
        lane_en  = 4'b0011 << off;
        wlanes   = {2{wdata[15:0]}};
        ldata    = {{16{~uns & sel_h[15]}}, sel_h};
      end
      MEM_SIZE_W: begin
        misalign = (off != 2'b00);
        lane_en  = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
    err = misalign | oor;
    if (err) lane_en = '0;
  end

endmodule

// File: rtl/data_mem.sv
// Byte-lane data memory with a valid/ready request/response interface.
// One response register; a new accept may overwrite it as it is popped.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [WORD_W-1:0]             mem [DEPTH_WORDS];
  logic [AW-1:0]                 idx;
  logic [WORD_W-1:0]             rword;
  logic [NUM_LANES-1:0]          lane_en;
  logic [NUM_LANES-1:0][LANE_W-1:0] wlanes;
  logic [WORD_W-1:0]             ldata;
  logic                          err;
  logic                          accept;
  mem_rsp_t                      rsp_q;

  assign idx       = req_addr[AW+1:2];
  assign rword     = mem[idx];
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  data_mem_align #(.DEPTH_WORDS(DEPTH_WORDS)) u_align (
    .size    (req_size),
    .uns     (req_unsigned),
    .addr    (req_addr),
    .wdata   (req_wdata),
    .rword   (rword),
    .lane_en (lane_en),
    .wlanes  (wlanes),
    .ldata   (ldata),
    .err     (err)
  );

  // lane_en is already cleared on error, so faulting stores write nothing.
  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_en[i]) mem[idx][i*LANE_W +: LANE_W] <= wlanes[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (accept) begin
      rsp_valid     <= 1'b1;
      rsp_q.err     <= err;
      rsp_q.rdata   <= (req_we || err) ? '0 : ldata;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_data_mem.sv
// Directed scoreboard bench for data_mem: the driver pushes expected
// responses, a monitor pops and compares on every response handshake.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];

  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  data_mem #(.DEPTH_WORDS(256), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor samples mid-low-phase, after the driver has settled its inputs.
  always @(negedge clk) begin
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got %08h err %0b expected none", rsp_rdata, rsp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
        chk("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic eerr, input logic [31:0] erd, output int stalls);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    stalls = 0;
    #1;
    while (!req_ready && stalls < 20) begin
      @(negedge clk); #1; stalls++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready %0b expected 1", req_ready);
    end else begin
      exp_q.push_back({eerr, erd});
      @(posedge clk); #1;
      chk("rsp_valid_after_accept", {31'd0, rsp_valid}, 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  int st;

  initial begin
    rst = 1'b1; req_valid = 0; req_we = 0; req_size = SW; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Word store/load and byte lane merging
    issue(1, SW, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, st);
    issue(0, SW, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, st);
    issue(1, SB, 0, 32'h13, 32'h00000080, 0, 32'h0, st);
    issue(0, SB, 0, 32'h13, 32'h0,        0, 32'hFFFFFF80, st);
    issue(0, SB, 1, 32'h13, 32'h0,        0, 32'h00000080, st);
    issue(0, SW, 0, 32'h10, 32'h0,        0, 32'h80ADBEEF, st);
    // Half store at upper half, signed/unsigned reads
    issue(1, SW, 0, 32'h30, 32'h00000000, 0, 32'h0, st);
    issue(1, SH, 0, 32'h32, 32'h00008001, 0, 32'h0, st);
    issue(0, SW, 0, 32'h30, 32'h0,        0, 32'h80010000, st);
    issue(0, SH, 0, 32'h32, 32'h0,        0, 32'hFFFF8001, st);
    issue(0, SH, 1, 32'h32, 32'h0,        0, 32'h00008001, st);
    issue(0, SB, 1, 32'h31, 32'h0,        0, 32'h00000000, st);
    // Error cases leave memory untouched
    issue(1, SW, 0, 32'h20, 32'h12345678, 0, 32'h0, st);
    issue(1, SH, 0, 32'h21, 32'h0000AAAA, 1, 32'h0, st);
    issue(0, SW, 0, 32'h20, 32'h0,        0, 32'h12345678, st);
    issue(0, SW, 0, 32'h22, 32'h0,        1, 32'h0, st);
    issue(0, SB, 0, 32'h400, 32'h0,       1, 32'h0, st);
    issue(1, SW, 0, 32'h410, 32'h55555555, 1, 32'h0, st);
    issue(0, SX, 0, 32'h20, 32'h0,        1, 32'h0, st);
    issue(1, SX, 0, 32'h20, 32'hFFFFFFFF, 1, 32'h0, st);
    issue(0, SW, 0, 32'h10, 32'h0,        0, 32'h80ADBEEF, st);
    issue(0, SW, 0, 32'h20, 32'h0,        0, 32'h12345678, st);

    // Backpressure: hold one response, stall the next request
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(0, SW, 0, 32'h10, 32'h0, 0, 32'h80ADBEEF, st);
    req_we = 0; req_size = SB; req_unsigned = 1; req_addr = 32'h13; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h80ADBEEF);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({1'b0, 32'h00000080});
    @(posedge clk); #1;
    chk("bp_next_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;

    // Streaming: alternating store/load pairs at full rate
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      v = 32'hA5000000 | (32'(i) << 8) | 32'(i * 3);
      issue(1, SW, 0, 32'h40 + 32'(i * 4), v, 0, 32'h0, st);
      chk("stream_store_stall", 32'(st), 32'd0);
      issue(0, SW, 0, 32'h40 + 32'(i * 4), 32'h0, 0, v, st);
      chk("stream_load_stall", 32'(st), 32'd0);
    end

    // Reset while a response is held
    issue(1, SW, 0, 32'h80, 32'hCAFEF00D, 0, 32'h0, st);
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(0, SW, 0, 32'h80, 32'h0, 0, 32'hCAFEF00D, st);
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    issue(0, SW, 0, 32'h80, 32'h0, 0, 32'hCAFEF00D, st);
    issue(0, SW, 0, 32'h10, 32'h0, 0, 32'h80ADBEEF, st);

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
